// File: rtl/rs_mul_sched.sv
// Reservation station and oldest-ready issue scheduler for the single-cycle multiplier.
// Define MUL_RS_CDB_BYPASS_EN to make a same-cycle CDB wakeup eligible and forward its data into issue.
`timescale 1ns/1ps
module rs_mul_sched #(
  parameter int unsigned RS_ENT_NUM = 4,
  parameter int unsigned TAG_WIDTH  = 6,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_dp_vld,
  output logic                  o_dp_rdy,
  input  logic                  i_dp_signed1,
  input  logic                  i_dp_signed2,
  input  logic                  i_dp_sel_high,
  input  logic [TAG_WIDTH-1:0]  i_dp_rob_tag,
  input  logic [DATA_WIDTH-1:0] i_dp_src1,
  input  logic                  i_dp_src1_rdy,
  input  logic [TAG_WIDTH-1:0]  i_dp_src1_tag,
  input  logic [DATA_WIDTH-1:0] i_dp_src2,
  input  logic                  i_dp_src2_rdy,
  input  logic [TAG_WIDTH-1:0]  i_dp_src2_tag,
  input  logic                  i_cdb_vld,
  input  logic [TAG_WIDTH-1:0]  i_cdb_tag,
  input  logic [DATA_WIDTH-1:0] i_cdb_data,
  input  logic                  i_exu_busy,
  output logic                  o_is_vld,
  output logic                  o_is_signed1,
  output logic                  o_is_signed2,
  output logic                  o_is_sel_high,
  output logic [DATA_WIDTH-1:0] o_is_src1,
  output logic [DATA_WIDTH-1:0] o_is_src2,
  output logic [TAG_WIDTH-1:0]  o_is_rob_tag,
  output logic                  o_wb_vld,
  output logic [TAG_WIDTH-1:0]  o_wb_rob_tag
);

  typedef struct packed {
    logic                  signed1;
    logic                  signed2;
    logic                  sel_high;
    logic [TAG_WIDTH-1:0]  rob_tag;
    logic                  src1_rdy;
    logic [TAG_WIDTH-1:0]  src1_tag;
    logic [DATA_WIDTH-1:0] src1;
    logic                  src2_rdy;
    logic [TAG_WIDTH-1:0]  src2_tag;
    logic [DATA_WIDTH-1:0] src2;
  } ent_t;

  ent_t                  ent_q   [RS_ENT_NUM];
  logic [RS_ENT_NUM-1:0] vld_q;
  logic [RS_ENT_NUM-1:0] older_q [RS_ENT_NUM];  // older_q[i][j]: entry j is older than entry i

  logic [RS_ENT_NUM-1:0] wake1_c, wake2_c, rdy1_c, rdy2_c;
  logic [RS_ENT_NUM-1:0] elig_c, sel_c, alloc_c, vld_nxt_c;
  logic                  dp_acc_c, alloc_found_c;
  ent_t                  dp_ent_c;
  logic                  is_s1_c, is_s2_c, is_sh_c;
  logic [DATA_WIDTH-1:0] is_src1_c, is_src2_c;
  logic [TAG_WIDTH-1:0]  is_tag_c;

  // CDB wakeup and oldest-eligible select
  always_comb begin
    wake1_c = '0;
    wake2_c = '0;
    rdy1_c  = '0;
    rdy2_c  = '0;
    sel_c   = '0;
    for (int i = 0; i < RS_ENT_NUM; i++) begin
      wake1_c[i] = i_cdb_vld && !ent_q[i].src1_rdy && (ent_q[i].src1_tag == i_cdb_tag);
      wake2_c[i] = i_cdb_vld && !ent_q[i].src2_rdy && (ent_q[i].src2_tag == i_cdb_tag);
`ifdef MUL_RS_CDB_BYPASS_EN
      rdy1_c[i]  = ent_q[i].src1_rdy || wake1_c[i];
      rdy2_c[i]  = ent_q[i].src2_rdy || wake2_c[i];
`else
      rdy1_c[i]  = ent_q[i].src1_rdy;
      rdy2_c[i]  = ent_q[i].src2_rdy;
`endif
    end
    elig_c = vld_q & rdy1_c & rdy2_c & {RS_ENT_NUM{!i_exu_busy && !i_flush}};
    for (int i = 0; i < RS_ENT_NUM; i++)
      sel_c[i] = elig_c[i] && ((older_q[i] & elig_c) == '0);
  end

  // Issue payload mux from the one-hot select
  always_comb begin
    is_s1_c   = 1'b0;
    is_s2_c   = 1'b0;
    is_sh_c   = 1'b0;
    is_src1_c = '0;
    is_src2_c = '0;
    is_tag_c  = '0;
    for (int i = 0; i < RS_ENT_NUM; i++) begin
      if (sel_c[i]) begin
        is_s1_c   = ent_q[i].signed1;
        is_s2_c   = ent_q[i].signed2;
        is_sh_c   = ent_q[i].sel_high;
        is_tag_c  = ent_q[i].rob_tag;
        is_src1_c = ent_q[i].src1;
        is_src2_c = ent_q[i].src2;
`ifdef MUL_RS_CDB_BYPASS_EN
        if (wake1_c[i]) is_src1_c = i_cdb_data;
        if (wake2_c[i]) is_src2_c = i_cdb_data;
`endif
      end
    end
  end

  // Dispatch: lowest free entry, capturing a same-cycle CDB broadcast
  always_comb begin
    alloc_c       = '0;
    alloc_found_c = 1'b0;
    dp_acc_c      = i_dp_vld && o_dp_rdy && !i_flush;
    for (int i = 0; i < RS_ENT_NUM; i++) begin
      if (dp_acc_c && !vld_q[i] && !alloc_found_c) begin
        alloc_c[i]    = 1'b1;
        alloc_found_c = 1'b1;
      end
    end
    dp_ent_c.signed1  = i_dp_signed1;
    dp_ent_c.signed2  = i_dp_signed2;
    dp_ent_c.sel_high = i_dp_sel_high;
    dp_ent_c.rob_tag  = i_dp_rob_tag;
    dp_ent_c.src1_rdy = i_dp_src1_rdy;
    dp_ent_c.src1_tag = i_dp_src1_tag;
    dp_ent_c.src1     = i_dp_src1;
    dp_ent_c.src2_rdy = i_dp_src2_rdy;
    dp_ent_c.src2_tag = i_dp_src2_tag;
    dp_ent_c.src2     = i_dp_src2;
    if (!i_dp_src1_rdy && i_cdb_vld && (i_dp_src1_tag == i_cdb_tag)) begin
      dp_ent_c.src1_rdy = 1'b1;
      dp_ent_c.src1     = i_cdb_data;
    end
    if (!i_dp_src2_rdy && i_cdb_vld && (i_dp_src2_tag == i_cdb_tag)) begin
      dp_ent_c.src2_rdy = 1'b1;
      dp_ent_c.src2     = i_cdb_data;
    end
    vld_nxt_c = i_flush ? '0 : ((vld_q & ~sel_c) | alloc_c);
  end

  // Entry storage, age matrix and free-slot flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      o_dp_rdy <= 1'b1;
      for (int i = 0; i < RS_ENT_NUM; i++) begin
        ent_q[i]   <= '0;
        older_q[i] <= '0;
      end
    end else begin
      vld_q    <= vld_nxt_c;
      o_dp_rdy <= ~&vld_nxt_c;
      for (int i = 0; i < RS_ENT_NUM; i++) begin
        if (alloc_c[i]) begin
          ent_q[i] <= dp_ent_c;
        end else begin
          if (wake1_c[i]) begin
            ent_q[i].src1     <= i_cdb_data;
            ent_q[i].src1_rdy <= 1'b1;
          end
          if (wake2_c[i]) begin
            ent_q[i].src2     <= i_cdb_data;
            ent_q[i].src2_rdy <= 1'b1;
          end
        end
        for (int j = 0; j < RS_ENT_NUM; j++) begin
          if (alloc_c[i])      older_q[i][j] <= vld_q[j];
          else if (alloc_c[j]) older_q[i][j] <= 1'b0;
        end
      end
    end
  end

  // Issue port and completion, one cycle behind issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_is_vld      <= 1'b0;
      o_is_signed1  <= 1'b0;
      o_is_signed2  <= 1'b0;
      o_is_sel_high <= 1'b0;
      o_is_src1     <= '0;
      o_is_src2     <= '0;
      o_is_rob_tag  <= '0;
      o_wb_vld      <= 1'b0;
      o_wb_rob_tag  <= '0;
    end else begin
      o_is_vld <= |sel_c;
      if (|sel_c) begin
        o_is_signed1  <= is_s1_c;
        o_is_signed2  <= is_s2_c;
        o_is_sel_high <= is_sh_c;
        o_is_src1     <= is_src1_c;
        o_is_src2     <= is_src2_c;
        o_is_rob_tag  <= is_tag_c;
      end
      o_wb_vld     <= o_is_vld && !i_flush;
      o_wb_rob_tag <= o_is_rob_tag;
    end
  end

endmodule
